// File: rtl/host_itf_pkg.sv
// rtl/host_itf_pkg.sv - host register map constants, decode selector type and 7-segment glyph table
package host_itf_pkg;

  localparam logic [19:0] ADDR_RW_BASE = 20'h00000;
  localparam logic [19:0] ADDR_RO_BASE = 20'h00800;
  localparam logic [19:0] ADDR_CMD     = 20'h01000;
  localparam logic [19:0] ADDR_STATUS  = 20'h01002;
  localparam logic [19:0] ADDR_ID      = 20'h01004;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RW,
    SEL_RO,
    SEL_CMD,
    SEL_STATUS,
    SEL_ID
  } sel_e;

  // Segment order {a,b,c,d,e,f,g}; values above 9 blank unless hex glyphs are enabled
  function automatic logic [6:0] seg_glyph(input logic [3:0] nibble, input logic hex);
    logic [6:0] g;
    case (nibble)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    if (!hex && nibble > 4'd9) g = 7'h00;
    return g;
  endfunction

endpackage

// File: rtl/host_reg_itf_seg_scan.sv
// rtl/host_reg_itf_seg_scan.sv - clock-enabled multi-digit 7-segment scanner
module seg_scan
  import host_itf_pkg::*;
#(
  parameter int NDIG     = 6,
  parameter int SCAN_DIV = 50000,
  parameter int DISP_HEX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG*4-1:0] i_disp_value,
  output logic [NDIG-1:0]   o_seg_com,
  output logic [7:0]        o_seg_data
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_dig;
  logic [NDIG-1:0] r_com;
  logic [7:0]      r_seg;
  logic            w_tick;
  logic [DW-1:0]   w_com_sel;
  logic [3:0]      w_nib;

  assign w_tick    = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_com_sel = DW'(NDIG - 1) - r_dig;
  assign w_nib     = i_disp_value[4*r_dig +: 4];

  // Digit select and glyph latch together on the tick so they never disagree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dig <= '0;
      r_com <= '1;
      r_seg <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_dig <= (r_dig == DW'(NDIG - 1)) ? '0 : r_dig + DW'(1);
        r_com <= ~(NDIG'(1) << w_com_sel);
        r_seg <= {seg_glyph(w_nib, DISP_HEX != 0), 1'b0};
      end
    end
  end

  assign o_seg_com  = r_com;
  assign o_seg_data = r_seg;

endmodule

// File: rtl/host_reg_itf.sv
// rtl/host_reg_itf.sv - host bus register file: synchronised strobes, atomic 32-bit config/result access, command strobe
module host_reg_itf
  import host_itf_pkg::*;
#(
  parameter int          NRW      = 4,
  parameter int          NRO      = 2,
  parameter int          NDIG     = 6,
  parameter int          SCAN_DIV = 50000,
  parameter int          DISP_HEX = 1,
  parameter logic [15:0] ID_WORD  = 16'hE5D1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              HOST_nCS,
  input  logic              HOST_nWE,
  input  logic              HOST_nOE,
  input  logic [20:0]       HOST_ADD,
  input  logic [15:0]       HDI,
  output logic [15:0]       HDO,
  output logic [NRW*32-1:0] cfg_regs,
  output logic [NRW-1:0]    cfg_wr_pulse,
  output logic [3:0]        proc_cmd,
  output logic              cmd_strobe,
  input  logic [3:0]        proc_status,
  input  logic [NRO*32-1:0] ro_regs,
  input  logic [NDIG*4-1:0] disp_value,
  output logic [NDIG-1:0]   SEG_COM,
  output logic [7:0]        SEG_DATA
);

  localparam int RW_IW = (NRW > 1) ? $clog2(NRW) : 1;
  localparam int RO_IW = (NRO > 1) ? $clog2(NRO) : 1;

  logic [1:0]       r_ncs_sync, r_nwe_sync, r_noe_sync;
  logic [1:0]       r_sync_ok;
  logic             r_wr_act_d, r_rd_act_d;
  logic [31:0]      r_cfg    [NRW];
  logic [15:0]      r_shadow [NRW];
  logic [15:0]      r_snap   [NRO];
  logic [NRW-1:0]   r_wr_pulse;
  logic [3:0]       r_cmd;
  logic             r_cmd_strobe;
  logic [15:0]      r_hdo;

  logic             w_wr_act, w_rd_act, w_commit, w_rd_rise;
  logic [19:0]      w_addr, w_rw_off, w_ro_off;
  logic [RW_IW-1:0] w_rw_idx;
  logic [RO_IW-1:0] w_ro_idx;
  logic             w_hi;
  sel_e             w_sel;
  logic [15:0]      w_rd_data;
  logic [31:0]      w_ro [NRO];
  logic             w_unused;

  for (genvar g = 0; g < NRO; g++) begin : g_ro
    assign w_ro[g] = ro_regs[32*g +: 32];
  end

  for (genvar g = 0; g < NRW; g++) begin : g_cfg
    assign cfg_regs[32*g +: 32] = r_cfg[g];
  end

  // Edge history is pinned active until the synchronisers carry post-reset samples,
  // so an access already under way at reset release never produces an edge
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_ncs_sync <= 2'b11;
      r_nwe_sync <= 2'b11;
      r_noe_sync <= 2'b11;
      r_sync_ok  <= 2'b00;
      r_wr_act_d <= 1'b1;
      r_rd_act_d <= 1'b1;
    end else begin
      r_ncs_sync <= {r_ncs_sync[0], HOST_nCS};
      r_nwe_sync <= {r_nwe_sync[0], HOST_nWE};
      r_noe_sync <= {r_noe_sync[0], HOST_nOE};
      r_sync_ok  <= {r_sync_ok[0], 1'b1};
      r_wr_act_d <= r_sync_ok[1] ? w_wr_act : 1'b1;
      r_rd_act_d <= r_sync_ok[1] ? w_rd_act : 1'b1;
    end
  end

  assign w_wr_act  = !r_ncs_sync[1] && !r_nwe_sync[1] && r_noe_sync[1];
  assign w_rd_act  = !r_ncs_sync[1] && !r_noe_sync[1];
  assign w_commit  = w_wr_act && !r_wr_act_d;
  assign w_rd_rise = w_rd_act && !r_rd_act_d;

  assign w_addr   = HOST_ADD[19:0];
  assign w_rw_off = w_addr - ADDR_RW_BASE;
  assign w_ro_off = w_addr - ADDR_RO_BASE;
  assign w_rw_idx = w_rw_off[RW_IW+1:2];
  assign w_ro_idx = w_ro_off[RO_IW+1:2];
  assign w_hi     = w_addr[1];
  assign w_unused = HOST_ADD[20];

  always_comb begin
    w_sel = SEL_NONE;
    if (w_rw_off < 20'(4*NRW))      w_sel = SEL_RW;
    else if (w_ro_off < 20'(4*NRO)) w_sel = SEL_RO;
    else if (w_addr == ADDR_CMD)    w_sel = SEL_CMD;
    else if (w_addr == ADDR_STATUS) w_sel = SEL_STATUS;
    else if (w_addr == ADDR_ID)     w_sel = SEL_ID;
  end

  always_comb begin
    w_rd_data = 16'h0000;
    case (w_sel)
      SEL_RW:     w_rd_data = w_hi ? r_cfg[w_rw_idx][31:16] : r_shadow[w_rw_idx];
      SEL_RO:     w_rd_data = w_hi ? r_snap[w_ro_idx] : w_ro[w_ro_idx][15:0];
      SEL_CMD:    w_rd_data = {12'h000, r_cmd};
      SEL_STATUS: w_rd_data = {12'h000, proc_status};
      SEL_ID:     w_rd_data = ID_WORD;
      default:    w_rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NRW; i++) begin
        r_cfg[i]    <= '0;
        r_shadow[i] <= '0;
      end
      for (int j = 0; j < NRO; j++) r_snap[j] <= '0;
      r_wr_pulse   <= '0;
      r_cmd        <= '0;
      r_cmd_strobe <= 1'b0;
      r_hdo        <= '0;
    end else begin
      r_wr_pulse   <= '0;
      r_cmd_strobe <= 1'b0;
      if (w_commit) begin
        case (w_sel)
          SEL_RW: begin
            if (w_hi) begin
              r_cfg[w_rw_idx]      <= {HDI, r_shadow[w_rw_idx]};
              r_wr_pulse[w_rw_idx] <= 1'b1;
            end else begin
              r_shadow[w_rw_idx] <= HDI;
            end
          end
          SEL_CMD: begin
            r_cmd        <= HDI[3:0];
            r_cmd_strobe <= 1'b1;
          end
          default: ;
        endcase
      end
      // Upper half is frozen when the low half is first read, giving a coherent word
      if (w_rd_rise && w_sel == SEL_RO && !w_hi) r_snap[w_ro_idx] <= w_ro[w_ro_idx][31:16];
      if (w_rd_act) r_hdo <= w_rd_data;
    end
  end

  assign HDO          = r_hdo;
  assign cfg_wr_pulse = r_wr_pulse;
  assign proc_cmd     = r_cmd;
  assign cmd_strobe   = r_cmd_strobe;

  seg_scan #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV),
    .DISP_HEX (DISP_HEX)
  ) u_seg_scan (
    .clk          (clk),
    .rst          (RESET),
    .i_disp_value (disp_value),
    .o_seg_com    (SEG_COM),
    .o_seg_data   (SEG_DATA)
  );

endmodule

// File: tb/tb_host_reg_itf.sv
// tb/tb_host_reg_itf.sv - scoreboard bench for host_reg_itf: host accesses and display scan
module tb_host_reg_itf;

  localparam int NRW = 4, NRO = 2, NDIG = 6, SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              RESET = 1'b1;
  logic              HOST_nCS = 1'b1, HOST_nWE = 1'b1, HOST_nOE = 1'b1;
  logic [20:0]       HOST_ADD = '0;
  logic [15:0]       HDI = '0;
  logic [15:0]       HDO;
  logic [NRW*32-1:0] cfg_regs;
  logic [NRW-1:0]    cfg_wr_pulse;
  logic [3:0]        proc_cmd;
  logic              cmd_strobe;
  logic [3:0]        proc_status = 4'h9;
  logic [NRO*32-1:0] ro_regs = '0;
  logic [NDIG*4-1:0] disp_value = 24'hFEDCBA;
  logic [NDIG-1:0]   SEG_COM;
  logic [7:0]        SEG_DATA;

  host_reg_itf #(
    .NRW(NRW), .NRO(NRO), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .DISP_HEX(1), .ID_WORD(16'hE5D1)
  ) dut (
    .clk(clk), .RESET(RESET), .HOST_nCS(HOST_nCS), .HOST_nWE(HOST_nWE), .HOST_nOE(HOST_nOE),
    .HOST_ADD(HOST_ADD), .HDI(HDI), .HDO(HDO), .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse),
    .proc_cmd(proc_cmd), .cmd_strobe(cmd_strobe), .proc_status(proc_status), .ro_regs(ro_regs),
    .disp_value(disp_value), .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum int {S_HDO, S_CFG, S_PULSE, S_CMD, S_STB, S_COM, S_SEG} sig_e;
  typedef struct {
    int          due;
    sig_e        sig;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic expect_at(input int due, input sig_e s, input int idx, input logic [31:0] e, input string nm);
    exp_t t;
    t.due = due; t.sig = s; t.idx = idx; t.exp = e; t.name = nm;
    sb.push_back(t);
  endtask

  function automatic logic [31:0] observe(input sig_e s, input int idx);
    case (s)
      S_HDO:   return {16'h0, HDO};
      S_CFG:   return cfg_regs[32*idx +: 32];
      S_PULSE: return {28'h0, cfg_wr_pulse};
      S_CMD:   return {28'h0, proc_cmd};
      S_STB:   return {31'h0, cmd_strobe};
      S_COM:   return {26'h0, SEG_COM};
      default: return {24'h0, SEG_DATA};
    endcase
  endfunction

  // Monitor: retires every expectation whose cycle has come, sampled mid-cycle
  always @(negedge clk) begin
    int k;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due <= cyc) begin
        logic [31:0] act;
        act = observe(sb[k].sig, sb[k].idx);
        n_vec++;
        if (act !== sb[k].exp) begin
          n_miss++;
          $display("FAIL %s: got %h, expected %h (cycle %0d)", sb[k].name, act, sb[k].exp, cyc);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic wr_start(input logic [20:0] a, input logic [15:0] d, output int c);
    @(negedge clk);
    HOST_ADD = a; HDI = d; HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b1;
    c = cyc;
  endtask

  task automatic rd_start(input logic [20:0] a, output int c);
    @(negedge clk);
    HOST_ADD = a; HOST_nCS = 1'b0; HOST_nWE = 1'b1; HOST_nOE = 1'b0;
    c = cyc;
  endtask

  task automatic end_acc(input int hold);
    repeat (hold) @(negedge clk);
    HOST_nCS = 1'b1; HOST_nWE = 1'b1; HOST_nOE = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd_check(input logic [20:0] a, input logic [15:0] e, input string nm);
    int c;
    rd_start(a, c);
    expect_at(c + 3, S_HDO, 0, {16'h0, e}, nm);
    end_acc(6);
  endtask

  logic [5:0] com_tab [6];
  logic [7:0] seg_tab [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, r;
    com_tab = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
    seg_tab = '{8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    repeat (3) @(negedge clk);
    RESET = 1'b0;
    r = cyc;
    for (int i = 0; i < NRW; i++) expect_at(r + 1, S_CFG, i, 32'h0, "reset_cfg");
    expect_at(r + 1, S_HDO, 0, 32'h0, "reset_hdo");
    expect_at(r + 1, S_PULSE, 0, 32'h0, "reset_pulse");
    expect_at(r + 1, S_CMD, 0, 32'h0, "reset_cmd");
    expect_at(r + 1, S_STB, 0, 32'h0, "reset_strobe");
    expect_at(r + 1, S_SEG, 0, 32'h0, "reset_seg_data");
    expect_at(r + 3, S_COM, 0, 32'h3F, "seg_com_before_first_tick");
    // Digit k occupies cycles r+4+4k .. r+7+4k; k=6 checks the wrap to digit 0
    for (int k = 0; k <= 6; k++) begin
      expect_at(r + 4 + 4*k, S_COM, 0, {26'h0, com_tab[k % 6]}, "seg_com_first");
      expect_at(r + 7 + 4*k, S_COM, 0, {26'h0, com_tab[k % 6]}, "seg_com_last");
      expect_at(r + 4 + 4*k, S_SEG, 0, {24'h0, seg_tab[k % 6]}, "seg_data");
    end

    wr_start(21'h00008, 16'h1234, c);
    expect_at(c + 3, S_CFG, 2, 32'h0, "cfg2_after_low_half");
    expect_at(c + 3, S_PULSE, 0, 32'h0, "pulse_after_low_half");
    end_acc(6);

    wr_start(21'h0000A, 16'hABCD, c);
    expect_at(c + 2, S_CFG, 2, 32'h0, "cfg2_before_commit");
    expect_at(c + 3, S_CFG, 2, 32'hABCD1234, "cfg2_after_high_half");
    expect_at(c + 2, S_PULSE, 0, 32'h0, "pulse2_before");
    expect_at(c + 3, S_PULSE, 0, 32'h4, "pulse2_on");
    expect_at(c + 4, S_PULSE, 0, 32'h0, "pulse2_off");
    end_acc(6);

    wr_start(21'h00006, 16'h5555, c);
    expect_at(c + 3, S_CFG, 1, 32'h55550000, "cfg1_high_without_low");
    expect_at(c + 3, S_PULSE, 0, 32'h2, "pulse1_on");
    end_acc(6);

    wr_start(21'h01000, 16'h0005, c);
    expect_at(c + 3, S_CMD, 0, 32'h5, "cmd_value");
    expect_at(c + 2, S_STB, 0, 32'h0, "strobe_before");
    expect_at(c + 3, S_STB, 0, 32'h1, "strobe_on");
    expect_at(c + 4, S_STB, 0, 32'h0, "strobe_off");
    expect_at(c + 19, S_STB, 0, 32'h0, "strobe_long_hold");
    end_acc(20);

    wr_start(21'h01000, 16'h0005, c);
    expect_at(c + 3, S_STB, 0, 32'h1, "strobe_same_value");
    expect_at(c + 4, S_STB, 0, 32'h0, "strobe_same_value_off");
    end_acc(6);

    ro_regs[63:32] = 32'h0000FFFF;
    rd_check(21'h00804, 16'hFFFF, "ro1_low");
    ro_regs[63:32] = 32'h00010000;
    rd_check(21'h00806, 16'h0000, "ro1_high_snapshot");
    rd_check(21'h00804, 16'h0000, "ro1_low_new");
    rd_check(21'h00806, 16'h0001, "ro1_high_new");

    rd_check(21'h0000A, 16'hABCD, "rw2_high");
    rd_check(21'h00008, 16'h1234, "rw2_shadow");
    rd_check(21'h01000, 16'h0005, "cmd_read");
    rd_check(21'h01002, 16'h0009, "status_read");

    rd_start(21'h01004, c);
    expect_at(c + 2, S_HDO, 0, 32'h0009, "id_latency_prev");
    expect_at(c + 3, S_HDO, 0, 32'hE5D1, "id_read");
    expect_at(c + 9, S_HDO, 0, 32'hE5D1, "hdo_holds");
    end_acc(6);
    rd_check(21'h00FFE, 16'h0000, "unmapped_read");

    @(negedge clk);
    HOST_ADD = 21'h00008; HDI = 16'hFFFF; HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b0;
    c = cyc;
    expect_at(c + 3, S_HDO, 0, 32'h1234, "we_oe_reads_shadow");
    expect_at(c + 3, S_PULSE, 0, 32'h0, "we_oe_no_pulse");
    expect_at(c + 6, S_CFG, 2, 32'hABCD1234, "we_oe_cfg_kept");
    end_acc(6);

    wr_start(21'h0000A, 16'h0000, c);
    expect_at(c + 3, S_CFG, 2, 32'h00001234, "shadow_kept_after_we_oe");
    end_acc(6);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: never checked, expected %h", sb[0].name, sb[0].exp);
      sb.delete(0);
    end

    @(negedge clk);
    n_vec++;
    if (cfg_regs[31:0] !== 32'h00000000) begin
      n_miss++;
      $display("FAIL final_cfg0: got %h", cfg_regs[31:0]);
    end
    n_vec++;
    if (cfg_regs[63:32] !== 32'h55550000) begin
      n_miss++;
      $display("FAIL final_cfg1: got %h", cfg_regs[63:32]);
    end
    n_vec++;
    if (cfg_regs[95:64] !== 32'h00001234) begin
      n_miss++;
      $display("FAIL final_cfg2: got %h", cfg_regs[95:64]);
    end
    n_vec++;
    if (cfg_regs[127:96] !== 32'h00000000) begin
      n_miss++;
      $display("FAIL final_cfg3: got %h", cfg_regs[127:96]);
    end
    n_vec++;
    if (proc_cmd !== 4'h5) begin
      n_miss++;
      $display("FAIL final_cmd: got %h", proc_cmd);
    end
    n_vec++;
    if (HDO !== 16'h1234) begin
      n_miss++;
      $display("FAIL final_hdo: got %h", HDO);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
